modulator_scheduler: RTL and testbench

Shares the digital modulator / PWM transmit path between two requesters. Each requester submits a command {mode, message, cnt} over a req/ack handshake. A round-robin arbiter picks the winner and issues a one-cycle `send` with the latched command fields. The block then holds the path busy for the symbol time before granting again. It sits directly upstream of the system's `send`/`mode`/`message`/`cnt` inputs.

---
 rtl/modsched_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/modulator_scheduler.sv | 112 +++++++++++
 tb/tb_modulator_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modsched_pkg.sv
// rtl/modsched_pkg.sv - shared types, field widths and counter sizing for the modulator scheduler
// Contents: state_t (IDLE/ISSUE/HOLD), MSG_W, CNT_W, REP_MAX, ctr_width().
package modsched_pkg;

    localparam int MSG_W   = 5;
    localparam int CNT_W   = 3;
    localparam int REP_MAX = 1 << CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Hold counter must represent REP_MAX*symbol_cycles-1, the longest hold minus one.
    function automatic int ctr_width(input int symbol_cycles);
        return $clog2(REP_MAX * symbol_cycles);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter with update-on-grant pointer
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req[1:0]     request vector
//   update       commit the current winner into the pointer
//   gnt_idx      index of the winner (valid when any_req)
//   any_req      at least one request present
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt_idx,
    output logic       any_req
);

    // Reset to 1 so requester 0 wins the first tie.
    logic last_grant;

    always_comb begin
        any_req = req[0] | req[1];
        if (req[0] && req[1]) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update && any_req) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/modulator_scheduler.sv
// rtl/modulator_scheduler.sv - shares the modulator/PWM transmit path between two requesters
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0/1, mode0/1, message0/1,  pending command per requester, held until ack
//   cnt0/1
//   ack0, ack1                    one-cycle capture pulse to the winner
//   send                          one-cycle start strobe to the modulator
//   mode, message, cnt            latched command fields
//   busy                          path occupied (ISSUE or HOLD)
//   done                          one-cycle pulse in the IDLE cycle after the hold
//   grant                         requester being served
module modulator_scheduler
    import modsched_pkg::*;
#(
    parameter int SYMBOL_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             mode0,
    input  logic             mode1,
    input  logic [MSG_W-1:0] message0,
    input  logic [MSG_W-1:0] message1,
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             send,
    output logic             mode,
    output logic [MSG_W-1:0] message,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             grant
);

    localparam int CTR_W = ctr_width(SYMBOL_CYCLES);

    state_t           state;
    logic [CTR_W-1:0] hold_ctr;
    logic [CTR_W-1:0] hold_load;
    logic             gnt_idx;
    logic             any_req;
    logic             capture;

    // Requests are only looked at in IDLE; while busy they simply stay pending.
    assign capture = (state == IDLE) && any_req;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1, req0}),
        .update  (capture),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // N-1 = (cnt+1)*S-1 rewritten as cnt*S + (S-1): every intermediate stays
    // below 8*S, so nothing overflows the counter width.
    assign hold_load = CTR_W'(cnt) * CTR_W'(SYMBOL_CYCLES) + CTR_W'(SYMBOL_CYCLES - 1);

    assign send = (state == ISSUE);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_ctr <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done     <= 1'b0;
            grant    <= 1'b0;
            mode     <= 1'b0;
            message  <= '0;
            cnt      <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        mode    <= gnt_idx ? mode1    : mode0;
                        message <= gnt_idx ? message1 : message0;
                        cnt     <= gnt_idx ? cnt1     : cnt0;
                        grant   <= gnt_idx;
                        ack0    <= ~gnt_idx;
                        ack1    <= gnt_idx;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    hold_ctr <= hold_load;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_ctr == '0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        hold_ctr <= hold_ctr - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulator_scheduler.sv
// tb/tb_modulator_scheduler.sv - self-checking bench for modulator_scheduler
module tb_modulator_scheduler;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       mode0 = 1'b0, mode1 = 1'b0;
    logic [4:0] message0 = '0, message1 = '0;
    logic [2:0] cnt0 = '0, cnt1 = '0;
    logic       ack0, ack1, send, mode, busy, done, grant;
    logic [4:0] message;
    logic [2:0] cnt;

    modulator_scheduler #(.SYMBOL_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .mode0    (mode0),
        .mode1    (mode1),
        .message0 (message0),
        .message1 (message1),
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .ack0     (ack0),
        .ack1     (ack1),
        .send     (send),
        .mode     (mode),
        .message  (message),
        .cnt      (cnt),
        .busy     (busy),
        .done     (done),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: one record per captured command, expressed as the
    // cycle numbers at which its send, busy window and done occur.
    int m_send_at  = -1000;
    int m_busy_end = -1000;
    int m_done_at  = -1000;
    int m_last     = 1;
    int m_grant    = 0;
    int m_mode     = 0;
    int m_msg      = 0;
    int m_cnt      = 0;

    // Observations of the DUT, used by the scenario-level checks.
    int   send_cyc[$];
    int   send_grant[$];
    int   hold_len[$];
    int   hold_run = 0;
    logic prev_busy = 1'b0;
    int   ack0_seen = 0, ack1_seen = 0, done_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        int w;
        if (rst) begin
            m_send_at  = -1000;
            m_busy_end = -1000;
            m_done_at  = -1000;
            m_last     = 1;
            m_grant    = 0;
            m_mode     = 0;
            m_msg      = 0;
            m_cnt      = 0;
        end else if (cyc > m_busy_end && (req0 || req1)) begin
            if (req0 && req1) w = (m_last == 0) ? 1 : 0;
            else              w = req1 ? 1 : 0;
            m_last     = w;
            m_grant    = w;
            m_mode     = (w == 1) ? int'(mode1)    : int'(mode0);
            m_msg      = (w == 1) ? int'(message1) : int'(message0);
            m_cnt      = (w == 1) ? int'(cnt1)     : int'(cnt0);
            m_send_at  = cyc + 1;
            m_busy_end = cyc + 1 + (m_cnt + 1) * SC;
            m_done_at  = m_busy_end + 1;
        end
    endtask

    task automatic check_cycle();
        bit is_send;
        is_send = (cyc == m_send_at);
        check_eq("send",    32'(send),    32'(is_send));
        check_eq("ack0",    32'(ack0),    32'(is_send && m_grant == 0));
        check_eq("ack1",    32'(ack1),    32'(is_send && m_grant == 1));
        check_eq("busy",    32'(busy),    32'(cyc >= m_send_at && cyc <= m_busy_end));
        check_eq("done",    32'(done),    32'(cyc == m_done_at));
        check_eq("grant",   32'(grant),   32'(m_grant));
        check_eq("mode",    32'(mode),    32'(m_mode));
        check_eq("message", 32'(message), 32'(m_msg));
        check_eq("cnt",     32'(cnt),     32'(m_cnt));
        if (send === 1'b1) begin
            send_cyc.push_back(cyc);
            send_grant.push_back(int'(grant));
        end
        if (ack0 === 1'b1) ack0_seen++;
        if (ack1 === 1'b1) ack1_seen++;
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1 && send !== 1'b1) begin
            hold_run++;
        end else if (busy !== 1'b1 && prev_busy) begin
            hold_len.push_back(hold_run);
            hold_run = 0;
        end
        prev_busy = (busy === 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run(input int n, input bit autodrop, input bit rnd);
        bool_loop: for (int i = 0; i < n; i++) begin
            if (rnd) rst = ($urandom_range(0, 399) == 0);
            tick();
            if (autodrop && cyc == m_send_at) begin
                if (m_grant == 0) req0 = 1'b0;
                else              req1 = 1'b0;
            end
            if (rnd) begin
                if (!req0 && $urandom_range(0, 3) == 0) begin
                    req0     = 1'b1;
                    mode0    = 1'($urandom);
                    message0 = 5'($urandom);
                    cnt0     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
                end else if (req0 && $urandom_range(0, 23) == 0) begin
                    req0 = 1'b0;
                end
                if (!req1 && $urandom_range(0, 3) == 0) begin
                    req1     = 1'b1;
                    mode1    = 1'($urandom);
                    message1 = 5'($urandom);
                    cnt1     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
                end else if (req1 && $urandom_range(0, 23) == 0) begin
                    req1 = 1'b0;
                end
            end
        end
    endtask

    int a0, a1, d0;

    initial begin
        // Reset: two cycles with rst high, then idle with no requests.
        rst = 1'b1;
        run(2, 1'b0, 1'b0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        run(4, 1'b0, 1'b0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single request.
        d0 = done_seen;
        req0 = 1'b1; mode0 = 1'b1; message0 = 5'h15; cnt0 = 3'd0;
        run(1, 1'b1, 1'b0);
        check_eq("single_ack0", 32'(ack0), 32'd1);
        check_eq("single_send", 32'(send), 32'd1);
        check_eq("single_msg", 32'(message), 32'h15);
        check_eq("single_grant", 32'(grant), 32'd0);
        run(8, 1'b1, 1'b0);
        check_eq("single_hold_seen", 32'(hold_len.size() > 0), 32'd1);
        if (hold_len.size() > 0) check_eq("single_hold_len", 32'(hold_len[$]), 32'd4);
        check_eq("single_done_count", 32'(done_seen - d0), 32'd1);

        // Contention from reset, cnt=1 on both.
        rst = 1'b1;
        run(1, 1'b0, 1'b0);
        rst = 1'b0;
        send_cyc.delete(); send_grant.delete();
        a1 = ack1_seen;
        req0 = 1'b1; req1 = 1'b1; cnt0 = 3'd1; cnt1 = 3'd1;
        message0 = 5'h0a; message1 = 5'h13; mode0 = 1'b0; mode1 = 1'b1;
        run(25, 1'b1, 1'b0);
        check_eq("cont_sends", 32'(send_cyc.size()), 32'd2);
        if (send_cyc.size() >= 2) begin
            check_eq("cont_spacing", 32'(send_cyc[1] - send_cyc[0]), 32'd10);
            check_eq("cont_first", 32'(send_grant[0]), 32'd0);
            check_eq("cont_second", 32'(send_grant[1]), 32'd1);
        end
        check_eq("cont_ack1_count", 32'(ack1_seen - a1), 32'd1);

        // Fairness with both requests held continuously.
        rst = 1'b1;
        run(1, 1'b0, 1'b0);
        rst = 1'b0;
        send_grant.delete();
        req0 = 1'b1; req1 = 1'b1; cnt0 = 3'd0; cnt1 = 3'd0;
        run(26, 1'b0, 1'b0);
        check_eq("fair_sends", 32'(send_grant.size() >= 4), 32'd1);
        if (send_grant.size() >= 4) begin
            for (int i = 0; i < 4; i++) check_eq("fair_grant", 32'(send_grant[i]), 32'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        run(10, 1'b0, 1'b0);

        // Withdrawal while busy, then maximum count.
        rst = 1'b1;
        run(1, 1'b0, 1'b0);
        rst = 1'b0;
        req0 = 1'b1; cnt0 = 3'd0;
        run(2, 1'b1, 1'b0);
        a1 = ack1_seen;
        req1 = 1'b1; cnt1 = 3'd2; message1 = 5'h1f;
        run(2, 1'b0, 1'b0);
        req1 = 1'b0;
        run(6, 1'b0, 1'b0);
        check_eq("withdraw_no_ack1", 32'(ack1_seen - a1), 32'd0);
        check_eq("withdraw_idle", 32'(busy), 32'd0);
        req0 = 1'b1; cnt0 = 3'd7; message0 = 5'h07;
        run(40, 1'b1, 1'b0);
        check_eq("max_hold_seen", 32'(hold_len.size() > 0), 32'd1);
        if (hold_len.size() > 0) check_eq("max_hold_len", 32'(hold_len[$]), 32'd32);

        // Reset in the middle of HOLD with req0 still pending.
        rst = 1'b1;
        run(1, 1'b0, 1'b0);
        rst = 1'b0;
        d0 = done_seen;
        a0 = ack0_seen;
        req0 = 1'b1; cnt0 = 3'd3; message0 = 5'h0c;
        run(3, 1'b0, 1'b0);
        check_eq("midhold_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        run(1, 1'b0, 1'b0);
        check_eq("midhold_rst_busy", 32'(busy), 32'd0);
        check_eq("midhold_rst_msg", 32'(message), 32'd0);
        rst = 1'b0;
        run(1, 1'b0, 1'b0);
        check_eq("recapture_ack0", 32'(ack0), 32'd1);
        check_eq("recapture_send", 32'(send), 32'd1);
        req0 = 1'b0;
        run(20, 1'b0, 1'b0);
        check_eq("midhold_done_count", 32'(done_seen - d0), 32'd1);
        check_eq("midhold_ack0_count", 32'(ack0_seen - a0), 32'd2);

        // Randomized traffic, including occasional resets and withdrawals.
        run(3000, 1'b1, 1'b1);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        run(40, 1'b0, 1'b0);
        check_eq("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
